credit_tx_fifo: RTL and testbench
=================================

Name: credit_tx_fifo

Overview:
Producer-side counterpart of a downstream one-hot-tracked buffer. It accepts entries from a local producer into a small FIFO and issues them to a downstream buffer with no ready signal. Issue is gated by a credit count that mirrors the downstream buffer's free slots; each downstream pop returns one credit. It sits between an issuing pipeline stage and a remote queue, so downstream overflow is impossible by construction.

Parameters:
DATA_WIDTH, 32, width of each entry.
CREDITS, 4, depth of the downstream buffer, i.e. initial credit count; must be >= 1.
TX_DEPTH, 2, local FIFO depth; must be >= 1.

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
in_valid  in  1  producer has an entry.
in_data  in  DATA_WIDTH  producer entry.
in_ready  out  1  local FIFO not full; a push occurs when in_valid & in_ready.
tx_valid  out  1  registered one-cycle issue strobe to downstream (downstream push).
tx_data  out  DATA_WIDTH  registered issued entry; valid only while tx_valid=1.
credit_return  in  1  one-cycle pulse per downstream pop.
credit_count  out  $clog2(CREDITS+1)  current credits held, 0..CREDITS.
no_credits  out  1  credit_count == 0.
idle  out  1  local FIFO empty, credit_count == CREDITS, tx_valid == 0.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Local FIFO emptied.
  - Credit vector set to one-hot bit CREDITS.
  - Outputs: tx_valid=0, tx_data=0, in_ready=1, credit_count=CREDITS, no_credits=0, idle=1.
  - Reset mid-operation discards buffered entries and restores all credits. The downstream side must be reset in the same cycle.
- Credit state:
  - One-hot vector [CREDITS:0]. Bit k set means k credits.
  - credit_count is the binary encoding of that vector.
- Issue condition (evaluated each cycle from registered state): issue = local_not_empty & ~no_credits.
- On an edge with issue=1:
  - tx_valid<=1 and tx_data<=FIFO head.
  - Head is popped.
  - One credit is consumed.
- On an edge with issue=0: tx_valid<=0; tx_data holds its value.
- Credit update per edge, from {issue, credit_return}:
  - 10: shift down (count -1).
  - 01: shift up (count +1).
  - 11 or 00: hold.
- Credits are registered only. A credit returned at edge N enables issue at edge N+1, and tx_valid is seen in the cycle after N+1. There is no combinational path from credit_return to tx_valid.
- Latency: an entry pushed at edge N into an empty FIFO with credits available produces tx_valid=1 in the cycle after edge N+1 (2 cycles). There is no bypass.
- Sustained throughput: 1 entry/cycle while credits > 0 and the FIFO is non-empty.
- Local FIFO:
  - Circular buffer with read/write pointers wrapping at TX_DEPTH.
  - Occupancy tracked as a one-hot vector [TX_DEPTH:0].
  - in_ready = ~full, from registered state only. A push to a full FIFO is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
  - Push into an empty FIFO with a same-cycle issue cannot occur, since issue needs non-empty at the start of the cycle.
- Ordering: strict FIFO; tx_data order equals acceptance order.
- Error conditions (simulation assertions, outside reset):
  - credit_return while credit_count == CREDITS: $error("credit overflow"); the vector holds.
  - Issue with no credits is structurally impossible; assert anyway.
- no_credits and idle are combinational from registered state.

Test Plan:
- Reset, then push A at edge 0 -> tx_valid=1, tx_data=A in the cycle after edge 1; credit_count 4->3; idle=0.
- Push 6 entries back-to-back with no credit_return (CREDITS=4, TX_DEPTH=2) -> exactly 4 tx_valid pulses on consecutive cycles; credit_count=0, no_credits=1; 2 entries held; in_ready=0 once the FIFO fills; no further tx_valid.
- From the previous state, pulse credit_return at edge N -> tx_valid at edge N+1 with the 5th entry; credit_count returns to 0; order preserved.
- Steady state at credit_count=2 with the FIFO non-empty and credit_return every cycle -> tx_valid every cycle; credit_count stays 2 (issue and return same cycle = hold).
- Assert rst with 2 entries buffered and 3 credits outstanding -> next cycle: credit_count=4, in_ready=1, tx_valid=0, idle=1; buffered entries never issued.
- credit_return while credit_count=4 -> "credit overflow" error fires; credit_count stays 4.

Source files
------------

// File: rtl/credit_tx_fifo.sv
// credit_tx_fifo: local FIFO issuing entries downstream, gated by a one-hot credit count
module credit_tx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS = 4,
  parameter int TX_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic in_ready,
  output logic tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic credit_return,
  output logic [$clog2(CREDITS+1)-1:0] credit_count,
  output logic no_credits,
  output logic idle
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int PW = TX_DEPTH > 1 ? $clog2(TX_DEPTH) : 1;
  logic [DATA_WIDTH-1:0] mem [TX_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [TX_DEPTH:0] occ;
  logic [CREDITS:0] cred;
  logic empty, push, issue;
  assign empty = occ[0];
  assign in_ready = ~occ[TX_DEPTH];
  assign no_credits = cred[0];
  assign push = in_valid & in_ready;
  assign issue = ~empty & ~no_credits;
  assign idle = empty & cred[CREDITS] & ~tx_valid;
  always_comb begin
    credit_count = '0;
    for (int k = 0; k <= CREDITS; k++)
      credit_count = cred[k] ? (credit_count | CW'(k)) : credit_count;
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ <= (TX_DEPTH+1)'(1);
      cred <= (CREDITS+1)'(1) << CREDITS;
      tx_valid <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_valid <= issue;
      if (issue) tx_data <= mem[rd_ptr];
      if (issue) rd_ptr <= rd_ptr == PW'(TX_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr == PW'(TX_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (push & ~issue) occ <= occ << 1;
      else if (issue & ~push) occ <= occ >> 1;
      if (issue & ~credit_return) cred <= cred >> 1;
      else if (credit_return & ~issue & ~cred[CREDITS]) cred <= cred << 1;
      assert (!(credit_return && cred[CREDITS])) else $error("credit overflow");
      assert (!(issue && no_credits)) else $error("issue without credit");
    end
  end
endmodule

// File: tb/tb_credit_tx_fifo.sv
// tb_credit_tx_fifo: directed self-checking bench for credit_tx_fifo
module tb_credit_tx_fifo;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, tx_valid, credit_return, no_credits, idle;
  logic [31:0] in_data, tx_data;
  logic [2:0] credit_count;
  int n_assert = 0;
  int n_fail = 0;
  credit_tx_fifo #(.DATA_WIDTH(32), .CREDITS(4), .TX_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .credit_return(credit_return),
    .credit_count(credit_count), .no_credits(no_credits), .idle(idle)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_credits"}, 32'(credit_count), 4);
    chk({tag, "_no_credits"}, 32'(no_credits), 0);
    chk({tag, "_idle"}, 32'(idle), 1);
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    credit_return = 1'b0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk_reset_state("reset");
    chk("reset_tx_data", tx_data, 0);
    in_valid = 1'b1;
    in_data = 32'hA;
    step();
    in_valid = 1'b0;
    chk("lat_no_bypass", 32'(tx_valid), 0);
    chk("lat_idle", 32'(idle), 0);
    step();
    chk("lat_tx_valid", 32'(tx_valid), 1);
    chk("lat_tx_data", tx_data, 32'hA);
    chk("lat_credits", 32'(credit_count), 3);
    step();
    chk("lat_strobe_end", 32'(tx_valid), 0);
    chk("lat_hold_data", tx_data, 32'hA);
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    chk("ret_credits", 32'(credit_count), 4);
    chk("ret_idle", 32'(idle), 1);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data = 32'hD000_0000 + 32'(i);
      chk($sformatf("burst_ready_%0d", i), 32'(in_ready), 1);
      step();
      chk($sformatf("burst_valid_%0d", i), 32'(tx_valid), (i >= 1 && i <= 4) ? 1 : 0);
      if (i >= 1 && i <= 4) chk($sformatf("burst_data_%0d", i), tx_data, 32'hD000_0000 + 32'(i - 1));
    end
    chk("burst_credits", 32'(credit_count), 0);
    chk("burst_no_credits", 32'(no_credits), 1);
    chk("burst_full", 32'(in_ready), 0);
    in_data = 32'hBAD;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_valid_%0d", i), 32'(tx_valid), 0);
      chk($sformatf("stall_ready_%0d", i), 32'(in_ready), 0);
      step();
    end
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    chk("cr_no_comb_path", 32'(tx_valid), 0);
    chk("cr_credits_up", 32'(credit_count), 1);
    step();
    chk("cr_issue_valid", 32'(tx_valid), 1);
    chk("cr_issue_data", tx_data, 32'hD000_0004);
    chk("cr_credits_down", 32'(credit_count), 0);
    chk("cr_ready", 32'(in_ready), 1);
    step();
    chk("cr_single_pulse", 32'(tx_valid), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("rst2");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = 32'h5000_0000 + 32'(i);
      credit_return = i >= 3;
      step();
      chk($sformatf("ss_valid_%0d", i), 32'(tx_valid), i >= 1 ? 1 : 0);
      if (i >= 1) chk($sformatf("ss_data_%0d", i), tx_data, 32'h5000_0000 + 32'(i - 1));
      chk($sformatf("ss_credits_%0d", i), 32'(credit_count), i == 0 ? 4 : i == 1 ? 3 : 2);
    end
    in_valid = 1'b0;
    credit_return = 1'b0;
    step();
    chk("drain_data", tx_data, 32'h5000_0009);
    chk("drain_credits", 32'(credit_count), 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 32'h7000_0000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    chk("fill_full", 32'(in_ready), 0);
    chk("fill_no_credits", 32'(no_credits), 1);
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    chk("pre_rst_credits", 32'(credit_count), 1);
    chk("pre_rst_valid", 32'(tx_valid), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("rst_mid");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst_quiet_%0d", i), 32'(tx_valid), 0);
      chk($sformatf("post_rst_idle_%0d", i), 32'(idle), 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
